ntt_sequencer: RTL and testbench

Parametrised control sequencer for an in-place radix-2 NTT datapath. It replaces hard-wired glue logic with one FSM that runs three phases:
- load samples into bit-reversed locations;
- issue all butterfly read, write-back and twiddle indices for log2(N) stages, honouring PE and RAM latencies;
- stream results out in natural order.

It sits between the input stream, the coefficient RAM (two read ports, two write ports), the twiddle ROM and the PE. It carries no data; it drives addresses, enables and mux selects only.

---
 rtl/ntt_pkg.sv | 28 ++
 rtl/ntt_sequencer_if.sv | 41 ++++
 rtl/ntt_delay_line.sv | 35 +++
 rtl/ntt_sequencer.sv | 168 ++++++++++++++++
 tb/tb_ntt_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared state encoding, default sizing and the bit-reverse helper
// for the NTT control sequencer.
package ntt_pkg;

    localparam int RING_SIZE_DEF = 256;
    localparam int PE_LAT_DEF    = 3;
    localparam int RD_LAT_DEF    = 1;
    localparam int LOGN          = $clog2(RING_SIZE_DEF);
    localparam int PIPE_LAT      = RD_LAT_DEF + PE_LAT_DEF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMP,
        DRAIN,
        UNLOAD,
        FLUSH
    } state_e;

    // Reverses the low n bits of v; bits at and above n come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[5'(i)] = v[5'(n - 1 - i)];
        return r;
    endfunction

endpackage

// File: rtl/ntt_sequencer_if.sv
// ntt_sequencer_if: stream, RAM, twiddle and PE control signals of the sequencer.
// master is the sequencer side, slave the datapath/stream side.
interface ntt_sequencer_if
    import ntt_pkg::*;
#(
    parameter int AW = LOGN
);
    logic          in_valid;
    logic          in_ready;
    logic          inv;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr_top;
    logic [AW-1:0] rd_addr_bot;
    logic [AW-2:0] tw_idx;
    logic          tw_inv;
    logic          wb_we;
    logic [AW-1:0] wb_addr_top;
    logic [AW-1:0] wb_addr_bot;
    logic          din_sel;
    logic          out_valid;
    logic [AW-1:0] out_idx;
    logic          busy;
    logic          done;

    modport master (
        input  in_valid, inv,
        output in_ready, load_we, load_addr, rd_en, rd_addr_top, rd_addr_bot,
               tw_idx, tw_inv, wb_we, wb_addr_top, wb_addr_bot, din_sel,
               out_valid, out_idx, busy, done
    );

    modport slave (
        output in_valid, inv,
        input  in_ready, load_we, load_addr, rd_en, rd_addr_top, rd_addr_bot,
               tw_idx, tw_inv, wb_we, wb_addr_top, wb_addr_bot, din_sel,
               out_valid, out_idx, busy, done
    );

endinterface

// File: rtl/ntt_delay_line.sv
// ntt_delay_line: fixed-depth valid/data shift register with synchronous
// active-low clear, used to align write-back and output tags with the datapath.
module ntt_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [DEPTH-1:0]        valid_q;
    logic [DEPTH-1:0][W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/ntt_sequencer.sv
// ntt_sequencer: address/enable sequencer for an in-place radix-2 NTT:
// bit-reversed load, log2(N) butterfly stages, natural-order unload.
module ntt_sequencer
    import ntt_pkg::*;
#(
    parameter int RING_SIZE = RING_SIZE_DEF,
    parameter int PE_LAT    = PE_LAT_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    ntt_sequencer_if.master bus
);

    localparam int AW     = $clog2(RING_SIZE);
    localparam int WB_LAT = RD_LAT + PE_LAT;
    localparam int WW     = $clog2(WB_LAT + 1);
    localparam logic [AW-1:0] LAST       = AW'(RING_SIZE - 1);
    localparam logic [AW-1:0] LAST_STAGE = AW'(AW - 1);
    localparam logic [AW-2:0] LAST_BF    = '1;
    localparam logic [WW-1:0] DRAIN_END  = WW'(WB_LAT - 1);
    localparam logic [WW-1:0] FLUSH_END  = WW'(RD_LAT);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] stage_q, stage_d;
    logic [AW-2:0] bfly_q, bfly_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          inv_q, inv_d;

    logic          hs, load_we, rd_en, done, issue_bf, issue_out;
    logic [AW-1:0] load_addr, rd_top, rd_bot, m, j;
    logic [AW-2:0] tw;
    logic [2*AW-1:0] wb_pair;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        bfly_d    = bfly_q;
        wait_d    = wait_q;
        inv_d     = inv_q;
        load_we   = 1'b0;
        load_addr = '0;
        rd_en     = 1'b0;
        rd_top    = '0;
        rd_bot    = '0;
        tw        = '0;
        done      = 1'b0;
        hs        = bus.in_valid && reset && (state_q == IDLE || state_q == LOAD);
        m         = AW'(1) << stage_q;
        j         = AW'(bfly_q) & (m - AW'(1));
        case (state_q)
            IDLE: if (hs) begin
                load_we = 1'b1;
                inv_d   = bus.inv;
                cnt_d   = AW'(1);
                state_d = LOAD;
            end
            LOAD: if (hs) begin
                load_we   = 1'b1;
                load_addr = AW'(bitrev(32'(cnt_q), AW));
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    stage_d = '0;
                    bfly_d  = '0;
                    state_d = COMP;
                end
            end
            COMP: begin
                // group base is g*2m, j the offset inside the group
                rd_en  = 1'b1;
                rd_top = ((AW'(bfly_q) >> stage_q) << (stage_q + AW'(1))) | j;
                rd_bot = rd_top + m;
                tw     = (AW-1)'(j << (AW'(AW - 1) - stage_q));
                bfly_d = bfly_q + (AW-1)'(1);
                if (bfly_q == LAST_BF) begin
                    wait_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                wait_d = wait_q + WW'(1);
                if (wait_q == DRAIN_END) begin
                    wait_d  = '0;
                    bfly_d  = '0;
                    stage_d = (stage_q == LAST_STAGE) ? '0 : stage_q + AW'(1);
                    cnt_d   = '0;
                    state_d = (stage_q == LAST_STAGE) ? UNLOAD : COMP;
                end
            end
            UNLOAD: begin
                rd_en  = 1'b1;
                rd_top = cnt_q;
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    wait_d  = '0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                wait_d = wait_q + WW'(1);
                if (wait_q == FLUSH_END) begin
                    done    = 1'b1;
                    wait_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            bfly_q  <= '0;
            wait_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            wait_q  <= wait_d;
            inv_q   <= inv_d;
        end
    end

    // Only butterfly reads produce PE results, so only they are tagged for write-back.
    assign issue_bf  = state_q == COMP;
    assign issue_out = state_q == UNLOAD;

    ntt_delay_line #(.DEPTH(WB_LAT), .W(2 * AW)) u_wb_delay (
        .clk    (clk),
        .reset  (reset),
        .valid_i(issue_bf),
        .data_i (issue_bf ? {rd_top, rd_bot} : '0),
        .valid_o(bus.wb_we),
        .data_o (wb_pair)
    );

    ntt_delay_line #(.DEPTH(RD_LAT), .W(AW)) u_out_delay (
        .clk    (clk),
        .reset  (reset),
        .valid_i(issue_out),
        .data_i (issue_out ? cnt_q : '0),
        .valid_o(bus.out_valid),
        .data_o (bus.out_idx)
    );

    assign bus.wb_addr_top = wb_pair[2*AW-1:AW];
    assign bus.wb_addr_bot = wb_pair[AW-1:0];
    assign bus.in_ready    = state_q == IDLE || state_q == LOAD;
    assign bus.din_sel     = !(state_q == IDLE || state_q == LOAD);
    assign bus.busy        = state_q != IDLE;
    assign bus.load_we     = load_we;
    assign bus.load_addr   = load_addr;
    assign bus.rd_en       = rd_en;
    assign bus.rd_addr_top = rd_top;
    assign bus.rd_addr_bot = rd_bot;
    assign bus.tw_idx      = tw;
    assign bus.tw_inv      = inv_q;
    assign bus.done        = done;

endmodule

// File: tb/tb_ntt_sequencer.sv
// tb_ntt_sequencer: N=8, PE_LAT=3, RD_LAT=1 bench; expected load, read, write-back,
// output and done events are queued with their cycle stamps when stimulus is driven.
module tb_ntt_sequencer;

    localparam int N  = 8;
    localparam int AW = 3;

    typedef struct {
        int top;
        int bot;
        int tw;
    } bf_t;

    typedef struct {
        int st;
        int top;
        int bot;
        int tw;
        bit bf;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ntt_sequencer_if #(.AW(AW)) bus ();

    ntt_sequencer #(.RING_SIZE(N), .PE_LAT(3), .RD_LAT(1)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int  ld_tab[N];
    bf_t bf_tab[12];

    int  load_q[$];
    ev_t rd_q[$];
    ev_t wb_q[$];
    ev_t out_q[$];
    int  done_q[$];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  wb_after = 0;
    bit  mon_en = 1'b0;
    bit  quiet = 1'b0;
    bit  done_seen = 1'b0;
    bit  exp_inv = 1'b0;
    ev_t me;
    int  ma;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event, expected none (cycle %0d)", name, cyc);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        chk({name, "_in_ready"}, bus.in_ready, 1);
        chk({name, "_zero_outputs"},
            {bus.load_we, bus.rd_en, bus.wb_we, bus.out_valid, bus.busy, bus.done,
             bus.din_sel, bus.tw_inv, bus.load_addr, bus.rd_addr_top, bus.rd_addr_bot,
             bus.tw_idx, bus.wb_addr_top, bus.wb_addr_bot, bus.out_idx}, 0);
    endtask

    // c is the cycle of the last load handshake
    task automatic push_transform(input int c);
        int st, u0;
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 4; k++) begin
                st = c + 1 + s * 8 + k;
                rd_q.push_back('{st, bf_tab[s*4+k].top, bf_tab[s*4+k].bot, bf_tab[s*4+k].tw, 1'b1});
                wb_q.push_back('{st + 4, bf_tab[s*4+k].top, bf_tab[s*4+k].bot, 0, 1'b1});
            end
        u0 = c + 1 + 24;
        for (int i = 0; i < N; i++) begin
            rd_q.push_back('{u0 + i, i, 0, 0, 1'b0});
            out_q.push_back('{u0 + i + 1, i, 0, 0, 1'b0});
        end
        done_q.push_back(u0 + 9);
    endtask

    task automatic load8(input bit gapped, input bit inv_v);
        int i;
        bit gap;
        i = 0;
        gap = 1'b0;
        exp_inv = inv_v;
        while (i < N) begin
            if (gap) begin
                bus.in_valid = 1'b0;
                gap = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.inv = (i == 0) ? inv_v : ~inv_v;
                load_q.push_back(ld_tab[i]);
                if (i == N - 1) push_transform(cyc);
                i++;
                gap = gapped;
            end
            @(negedge clk);
            chk("in_ready_load", bus.in_ready, 1);
            next();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_seen && n < 200) begin
            next();
            n++;
        end
        if (!done_seen) unexpected("done_timeout");
        else begin
            chk("in_ready_after_done", bus.in_ready, 1);
            chk("busy_after_done", bus.busy, 0);
        end
        chk("rd_q_drained", rd_q.size(), 0);
        chk("wb_q_drained", wb_q.size(), 0);
        chk("out_q_drained", out_q.size(), 0);
        done_seen = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (quiet && (bus.wb_we || bus.rd_en)) wb_after++;
            if (bus.load_we) begin
                if (load_q.size() == 0) unexpected("load_we");
                else begin
                    ma = load_q.pop_front();
                    chk("load_addr", bus.load_addr, ma);
                end
            end
            if (bus.rd_en) begin
                if (rd_q.size() == 0) unexpected("rd_en");
                else begin
                    me = rd_q.pop_front();
                    chk("rd_cycle", cyc, me.st);
                    chk("rd_top", bus.rd_addr_top, me.top);
                    if (me.bf) begin
                        chk("rd_bot", bus.rd_addr_bot, me.bot);
                        chk("tw_idx", bus.tw_idx, me.tw);
                        chk("tw_inv", bus.tw_inv, exp_inv);
                    end
                end
            end
            if (bus.wb_we) begin
                if (wb_q.size() == 0) unexpected("wb_we");
                else begin
                    me = wb_q.pop_front();
                    chk("wb_cycle", cyc, me.st);
                    chk("wb_top", bus.wb_addr_top, me.top);
                    chk("wb_bot", bus.wb_addr_bot, me.bot);
                end
            end
            if (bus.out_valid) begin
                if (out_q.size() == 0) unexpected("out_valid");
                else begin
                    me = out_q.pop_front();
                    chk("out_cycle", cyc, me.st);
                    chk("out_idx", bus.out_idx, me.top);
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) unexpected("done");
                else begin
                    chk("done_cycle", cyc, done_q.pop_front());
                    chk("done_in_ready", bus.in_ready, 0);
                    done_seen = 1'b1;
                end
            end
        end
    end

    initial begin
        ld_tab = '{0, 4, 2, 6, 1, 5, 3, 7};
        bf_tab = '{'{0, 1, 0}, '{2, 3, 0}, '{4, 5, 0}, '{6, 7, 0},
                   '{0, 2, 0}, '{1, 3, 2}, '{4, 6, 0}, '{5, 7, 2},
                   '{0, 4, 0}, '{1, 5, 1}, '{2, 6, 2}, '{3, 7, 3}};
        bus.in_valid = 1'b0;
        bus.inv = 1'b0;
        next();
        next();
        bus.in_valid = 1'b1;
        #1 chk("handshake_in_reset", bus.load_we, 0);
        next();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        mon_en = 1'b1;
        check_idle("reset");

        load8(1'b0, 1'b0);
        wait_done();

        load8(1'b1, 1'b1);
        repeat (6) begin
            bus.in_valid = 1'b1;
            bus.inv = 1'b0;
            #1 chk("in_ready_comp", bus.in_ready, 0);
            next();
        end
        bus.in_valid = 1'b0;
        wait_done();

        load8(1'b0, 1'b0);
        repeat (10) next();
        chk("midcomp_top", bus.rd_addr_top, 4);
        chk("midcomp_bot", bus.rd_addr_bot, 6);
        reset = 1'b0;
        next();
        reset = 1'b1;
        rd_q.delete();
        wb_q.delete();
        out_q.delete();
        done_q.delete();
        check_idle("mid_reset");
        quiet = 1'b1;
        wb_after = 0;
        repeat (12) next();
        quiet = 1'b0;
        chk("no_issue_after_reset", wb_after, 0);

        load8(1'b0, 1'b1);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
